// File: rtl/forwarding_pkg.sv
// Shared types and helpers for the forwarding scoreboard: bypass select encoding and scoreboard count.
package forwarding_pkg;

   localparam int DEFAULT_NUM_STAGES  = 2;
   localparam int DEFAULT_MAX_PENDING = 4;
   localparam int FWD_SEL_W           = $clog2(DEFAULT_NUM_STAGES + 1);
   localparam int SB_COUNT_W          = $clog2(DEFAULT_MAX_PENDING + 1);

   typedef logic [FWD_SEL_W-1:0]  fwd_sel_t;
   typedef logic [SB_COUNT_W-1:0] sb_count_t;

   localparam fwd_sel_t FWD_SEL_RF = '0;

   function automatic int sel_w(input int num_stages);
      return $clog2(num_stages + 1);
   endfunction

endpackage

// File: rtl/fwd_priority_mux.sv
// Youngest-wins bypass select for one source address against all producer stages.
module fwd_priority_mux
   import forwarding_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int ADDR_W     = 5,
   parameter int SEL_W      = sel_w(NUM_STAGES)
) (
   input  logic [ADDR_W-1:0]            rs_i,
   input  logic [NUM_STAGES-1:0]        prod_reg_write_i,
   input  logic [NUM_STAGES*ADDR_W-1:0] prod_rd_i,
   input  logic [NUM_STAGES-1:0]        prod_data_valid_i,
   output logic [SEL_W-1:0]             sel_o,
   output logic                         not_ready_o
);

   always_comb begin
      sel_o       = SEL_W'(FWD_SEL_RF);
      not_ready_o = 1'b0;
      // Walk oldest to youngest so the youngest match overwrites older ones.
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (prod_reg_write_i[k] && (prod_rd_i[k*ADDR_W +: ADDR_W] == rs_i) &&
             (rs_i != {ADDR_W{1'b0}})) begin
            sel_o       = SEL_W'(k + 1);
            not_ready_o = ~prod_data_valid_i[k];
         end
      end
   end

endmodule

// File: rtl/forwarding_scoreboard.sv
// EX/ID operand bypass selection, load-use detection and multi-cycle op scoreboard.
// Optional FWD_STATS_EN adds saturating forward/stall event counters.
module forwarding_scoreboard
   import forwarding_pkg::*;
#(
   parameter int NUM_STAGES  = 2,
   parameter int NUM_SRC     = 2,
   parameter int ADDR_W      = 5,
   parameter int MAX_PENDING = 4,
   parameter int SEL_W       = sel_w(NUM_STAGES)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_STAGES-1:0]        prod_reg_write_i,
   input  logic [NUM_STAGES*ADDR_W-1:0] prod_rd_i,
   input  logic [NUM_STAGES-1:0]        prod_data_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0]    rs_ex_i,
   input  logic [NUM_SRC*ADDR_W-1:0]    rs_id_i,
   input  logic [NUM_SRC-1:0]           rs_id_used_i,
   input  logic [ADDR_W-1:0]            rd_id_i,
   input  logic                         rd_id_we_i,
   input  logic                         mc_issue_i,
   input  logic [ADDR_W-1:0]            mc_rd_i,
   input  logic                         mc_done_i,
   input  logic [ADDR_W-1:0]            mc_done_rd_i,
   input  logic                         flush_i,
   output logic [NUM_SRC*SEL_W-1:0]     alu_forward_o,
   output logic [NUM_SRC*SEL_W-1:0]     branch_forward_o,
   output logic                         stall_o,
   output logic                         mc_ready_o,
`ifdef FWD_STATS_EN
   output logic [31:0]                  fwd_count_o,
   output logic [31:0]                  stall_count_o,
`endif
   output logic                         sb_error_o
);

   localparam int NUM_REGS = 2 ** ADDR_W;
   localparam int CNT_W    = $clog2(MAX_PENDING + 1);

   logic [NUM_SRC*SEL_W-1:0] ex_sel_s;
   logic [NUM_SRC*SEL_W-1:0] id_sel_s;
   logic [NUM_SRC-1:0]       ex_nr_s;
   logic [NUM_SRC-1:0]       id_nr_s;

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                sb_error_q, sb_error_d;

   logic stall_s;
   logic ready_s;
   logic issue_acc_s;
   logic issue_err_s;
   logic done_ok_s;
   logic done_err_s;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_priority_mux #(
         .NUM_STAGES(NUM_STAGES),
         .ADDR_W    (ADDR_W),
         .SEL_W     (SEL_W)
      ) u_ex_mux (
         .rs_i             (rs_ex_i[s*ADDR_W +: ADDR_W]),
         .prod_reg_write_i (prod_reg_write_i),
         .prod_rd_i        (prod_rd_i),
         .prod_data_valid_i(prod_data_valid_i),
         .sel_o            (ex_sel_s[s*SEL_W +: SEL_W]),
         .not_ready_o      (ex_nr_s[s])
      );

      fwd_priority_mux #(
         .NUM_STAGES(NUM_STAGES),
         .ADDR_W    (ADDR_W),
         .SEL_W     (SEL_W)
      ) u_id_mux (
         .rs_i             (rs_id_i[s*ADDR_W +: ADDR_W]),
         .prod_reg_write_i (prod_reg_write_i),
         .prod_rd_i        (prod_rd_i),
         .prod_data_valid_i(prod_data_valid_i),
         .sel_o            (id_sel_s[s*SEL_W +: SEL_W]),
         .not_ready_o      (id_nr_s[s])
      );
   end

   assign ready_s = (count_q < CNT_W'(MAX_PENDING));

   always_comb begin
      stall_s = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (ex_nr_s[s]) begin
            stall_s = 1'b1;
         end
         // x0 can never be pending, so no explicit zero check is needed for sources.
         if (rs_id_used_i[s] && (id_nr_s[s] || pending_q[rs_id_i[s*ADDR_W +: ADDR_W]])) begin
            stall_s = 1'b1;
         end
      end
      if (rd_id_we_i && (rd_id_i != {ADDR_W{1'b0}}) && pending_q[rd_id_i]) begin
         stall_s = 1'b1;
      end
   end

   always_comb begin
      issue_acc_s = mc_issue_i && ready_s && (mc_rd_i != {ADDR_W{1'b0}});
      issue_err_s = mc_issue_i && !ready_s;
      done_ok_s   = mc_done_i && pending_q[mc_done_rd_i];
      done_err_s  = mc_done_i && !pending_q[mc_done_rd_i];

      pending_d  = pending_q;
      count_d    = count_q;
      sb_error_d = sb_error_q;
      if (flush_i) begin
         pending_d = '0;
         count_d   = '0;
      end else begin
         // Clear before set so a same-rd issue in the done cycle keeps the bit.
         if (done_ok_s) begin
            pending_d[mc_done_rd_i] = 1'b0;
         end
         if (issue_acc_s) begin
            pending_d[mc_rd_i] = 1'b1;
         end
         count_d = count_q + CNT_W'(issue_acc_s) - CNT_W'(done_ok_s);
         if (issue_err_s || done_err_s) begin
            sb_error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         count_q    <= '0;
         sb_error_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         count_q    <= count_d;
         sb_error_q <= sb_error_d;
      end
   end

   always_comb begin
      if (reset) begin
         alu_forward_o    = '0;
         branch_forward_o = '0;
         stall_o          = 1'b0;
         mc_ready_o       = 1'b0;
         sb_error_o       = 1'b0;
      end else begin
         alu_forward_o    = ex_sel_s;
         branch_forward_o = id_sel_s;
         stall_o          = stall_s;
         mc_ready_o       = ready_s;
         sb_error_o       = sb_error_q;
      end
   end

`ifdef FWD_STATS_EN
   logic [31:0] fwd_count_q, fwd_count_d;
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      fwd_count_d   = fwd_count_q;
      stall_count_d = stall_count_q;
      if ((ex_sel_s != '0) && (fwd_count_q != 32'hFFFF_FFFF)) begin
         fwd_count_d = fwd_count_q + 32'd1;
      end
      if (stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_count_q   <= 32'd0;
         stall_count_q <= 32'd0;
      end else begin
         fwd_count_q   <= fwd_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fwd_count_o   = reset ? 32'd0 : fwd_count_q;
   assign stall_count_o = reset ? 32'd0 : stall_count_q;
`endif

endmodule
